// File: rtl/mw_stage.sv
// Memory stage and M/W pipeline register: drives the data bus, checks address
// exceptions for CP0, extends load data and registers results into Writeback.
module mw_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] DM_TOP   = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ins,
  input  logic [31:0] M_alu_res,
  input  logic [31:0] M_mlu_res,
  input  logic [31:0] M_rt_data,
  input  logic [31:0] M_cp0_rd,
  input  logic [3:0]  M_mem_op,
  input  logic        M_addr_ov,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic [4:0]  M_exc_code,
  output logic [31:0] W_PC,
  output logic [31:0] W_ins,
  output logic [31:0] W_alu_res,
  output logic [31:0] W_mlu_res,
  output logic [31:0] W_mem_read,
  output logic [31:0] W_cp0_rd
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  logic        is_load_s, is_store_s, word_s, half_s;
  logic        in_dm_s, in_tmr_s, fault_s;
  logic [4:0]  exc_s;
  logic [3:0]  byteen_s;
  logic [31:0] wdata_s, load_s;
  logic [15:0] half_sel_s;
  logic [7:0]  byte_sel_s;
  logic [1:0]  off_s;

  assign off_s       = M_alu_res[1:0];
  assign m_data_addr = M_alu_res;
  assign M_exc_code  = exc_s;

  // Decode access class and width from the memory opcode
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    word_s     = 1'b0;
    half_s     = 1'b0;
    case (M_mem_op)
      OP_LW:         begin is_load_s  = 1'b1; word_s = 1'b1; end
      OP_LH, OP_LHU: begin is_load_s  = 1'b1; half_s = 1'b1; end
      OP_LB, OP_LBU: begin is_load_s  = 1'b1; end
      OP_SW:         begin is_store_s = 1'b1; word_s = 1'b1; end
      OP_SH:         begin is_store_s = 1'b1; half_s = 1'b1; end
      OP_SB:         begin is_store_s = 1'b1; end
      default:       begin is_load_s  = 1'b0; end
    endcase
  end

  // Address legality; timers accept only full-word access and their offset 8 is read-only
  always_comb begin
    in_dm_s  = (M_alu_res <= DM_TOP);
    in_tmr_s = ((M_alu_res >= 32'h0000_7F00) && (M_alu_res <= 32'h0000_7F0B)) ||
               ((M_alu_res >= 32'h0000_7F10) && (M_alu_res <= 32'h0000_7F1B));
    fault_s  = (word_s && (off_s != 2'b00)) ||
               (half_s && off_s[0]) ||
               !(in_dm_s || in_tmr_s) ||
               M_addr_ov ||
               (in_tmr_s && !word_s) ||
               (is_store_s && in_tmr_s && (M_alu_res[3:0] == 4'h8));
    if (fault_s && is_load_s) begin
      exc_s = 5'd4;
    end else if (fault_s && is_store_s) begin
      exc_s = 5'd5;
    end else begin
      exc_s = 5'd0;
    end
  end

  // Store lane placement
  always_comb begin
    byteen_s = 4'b0000;
    wdata_s  = 32'h0000_0000;
    case (M_mem_op)
      OP_SW: begin
        byteen_s = 4'b1111;
        wdata_s  = M_rt_data;
      end
      OP_SH: begin
        byteen_s = 4'b0011 << {off_s[1], 1'b0};
        wdata_s  = {2{M_rt_data[15:0]}};
      end
      OP_SB: begin
        byteen_s = 4'b0001 << off_s;
        wdata_s  = {4{M_rt_data[7:0]}};
      end
      default: begin
        byteen_s = 4'b0000;
        wdata_s  = 32'h0000_0000;
      end
    endcase
  end

  // The write only happens in the cycle M actually advances without a fault
  always_comb begin
    m_data_wdata = wdata_s;
    if ((exc_s == 5'd0) && !flush && !stall && reset) begin
      m_data_byteen = byteen_s;
    end else begin
      m_data_byteen = 4'b0000;
    end
  end

  // Load lane selection and extension
  always_comb begin
    half_sel_s = off_s[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    case (off_s)
      2'd0:    byte_sel_s = m_data_rdata[7:0];
      2'd1:    byte_sel_s = m_data_rdata[15:8];
      2'd2:    byte_sel_s = m_data_rdata[23:16];
      2'd3:    byte_sel_s = m_data_rdata[31:24];
      default: byte_sel_s = 8'h00;
    endcase
    case (M_mem_op)
      OP_LW:   load_s = m_data_rdata;
      OP_LH:   load_s = {{16{half_sel_s[15]}}, half_sel_s};
      OP_LHU:  load_s = {16'h0000, half_sel_s};
      OP_LB:   load_s = {{24{byte_sel_s[7]}}, byte_sel_s};
      OP_LBU:  load_s = {24'h00_0000, byte_sel_s};
      default: load_s = 32'h0000_0000;
    endcase
  end

  // M/W register: reset > flush > stall > advance; faulting instructions become bubbles
  always_ff @(posedge clk) begin
    if (!reset) begin
      W_PC       <= RESET_PC;
      W_ins      <= 32'h0000_0000;
      W_alu_res  <= 32'h0000_0000;
      W_mlu_res  <= 32'h0000_0000;
      W_mem_read <= 32'h0000_0000;
      W_cp0_rd   <= 32'h0000_0000;
    end else if (flush || (!stall && (exc_s != 5'd0))) begin
      W_PC       <= M_PC;
      W_ins      <= 32'h0000_0000;
      W_alu_res  <= 32'h0000_0000;
      W_mlu_res  <= 32'h0000_0000;
      W_mem_read <= 32'h0000_0000;
      W_cp0_rd   <= 32'h0000_0000;
    end else if (stall) begin
      W_PC       <= W_PC;
      W_ins      <= W_ins;
      W_alu_res  <= W_alu_res;
      W_mlu_res  <= W_mlu_res;
      W_mem_read <= W_mem_read;
      W_cp0_rd   <= W_cp0_rd;
    end else begin
      W_PC       <= M_PC;
      W_ins      <= M_ins;
      W_alu_res  <= M_alu_res;
      W_mlu_res  <= M_mlu_res;
      W_mem_read <= load_s;
      W_cp0_rd   <= M_cp0_rd;
    end
  end

endmodule

// File: tb/tb_mw_stage.sv
// Self-checking bench for mw_stage: table of M-stage vectors with a W-side
// scoreboard, plus hand-written reset, stall and flush sequences.
module tb_mw_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC, M_ins, M_alu_res, M_mlu_res, M_rt_data, M_cp0_rd;
  logic [3:0]  M_mem_op;
  logic        M_addr_ov, stall, flush;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic [4:0]  M_exc_code;
  logic [31:0] W_PC, W_ins, W_alu_res, W_mlu_res, W_mem_read, W_cp0_rd;

  always #5 clk = ~clk;

  mw_stage dut (
    .clk(clk), .reset(reset),
    .M_PC(M_PC), .M_ins(M_ins), .M_alu_res(M_alu_res), .M_mlu_res(M_mlu_res),
    .M_rt_data(M_rt_data), .M_cp0_rd(M_cp0_rd), .M_mem_op(M_mem_op),
    .M_addr_ov(M_addr_ov), .stall(stall), .flush(flush),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
    .M_exc_code(M_exc_code),
    .W_PC(W_PC), .W_ins(W_ins), .W_alu_res(W_alu_res), .W_mlu_res(W_mlu_res),
    .W_mem_read(W_mem_read), .W_cp0_rd(W_cp0_rd)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic        ov;
    logic [4:0]  exc;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wmem;
  } vec_t;

  typedef struct {
    logic [31:0] pc, ins, alu, mlu, mem, cp0;
  } w_t;

  vec_t vecs[$];
  w_t   exp_q[$];
  w_t   last_w;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                     input logic [31:0] rdata, input logic ov, input logic [4:0] exc,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] wmem);
    vec_t v;
    v.op = op; v.addr = addr; v.rt = rt; v.rdata = rdata; v.ov = ov;
    v.exc = exc; v.be = be; v.wd = wd; v.wmem = wmem;
    vecs.push_back(v);
  endtask

  task automatic drive_m(input int idx, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] rdata, input logic ov);
    M_PC         = 32'h0000_4000 + 32'(idx) * 32'd4;
    M_ins        = 32'h1000_0000 | 32'(idx);
    M_mlu_res    = 32'hA000_0000 | 32'(idx);
    M_cp0_rd     = 32'hC000_0000 | 32'(idx);
    M_mem_op     = op;
    M_alu_res    = addr;
    M_rt_data    = rt;
    m_data_rdata = rdata;
    M_addr_ov    = ov;
  endtask

  task automatic push_w(input logic bubble, input logic [31:0] mem);
    w_t e;
    e.pc  = M_PC;
    e.ins = bubble ? 32'h0 : M_ins;
    e.alu = bubble ? 32'h0 : M_alu_res;
    e.mlu = bubble ? 32'h0 : M_mlu_res;
    e.mem = bubble ? 32'h0 : mem;
    e.cp0 = bubble ? 32'h0 : M_cp0_rd;
    exp_q.push_back(e);
  endtask

  task automatic check_w(input string tag);
    w_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got W_PC %h expected an entry", tag, W_PC);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".W_PC"}, W_PC, e.pc);
      chk({tag, ".W_ins"}, W_ins, e.ins);
      chk({tag, ".W_alu_res"}, W_alu_res, e.alu);
      chk({tag, ".W_mlu_res"}, W_mlu_res, e.mlu);
      chk({tag, ".W_mem_read"}, W_mem_read, e.mem);
      chk({tag, ".W_cp0_rd"}, W_cp0_rd, e.cp0);
      last_w = e;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op addr rt rdata ov | exc be wdata wmem
    add(4'd8, 32'h0000_0006, 32'h1234_56AB, 32'h0, 1'b0, 5'd0, 4'b0100, 32'hABAB_ABAB, 32'h0);
    add(4'd7, 32'h0000_0002, 32'h1234_56AB, 32'h0, 1'b0, 5'd0, 4'b1100, 32'h56AB_56AB, 32'h0);
    add(4'd6, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    add(4'd8, 32'h0000_2FFF, 32'h0000_00C3, 32'h0, 1'b0, 5'd0, 4'b1000, 32'hC3C3_C3C3, 32'h0);
    add(4'd4, 32'h0000_0002, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'hFFFF_FFFF);
    add(4'd5, 32'h0000_0003, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0000_0080);
    add(4'd2, 32'h0000_0002, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'hFFFF_80FF);
    add(4'd1, 32'h0000_0000, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h80FF_7F01);
    add(4'd3, 32'h0000_0002, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0000_80FF);
    add(4'd4, 32'h0000_0000, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0000_0001);
    add(4'd2, 32'h0000_0000, 32'h0, 32'h80FF_7F01, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0000_7F01);
    add(4'd1, 32'h0000_7F00, 32'h0, 32'h1357_9BDF, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h1357_9BDF);
    add(4'd1, 32'h0000_2FFC, 32'h0, 32'h2468_ACE0, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h2468_ACE0);
    add(4'd6, 32'h0000_7F14, 32'h0BAD_F00D, 32'h0, 1'b0, 5'd0, 4'b1111, 32'h0BAD_F00D, 32'h0);
    add(4'd0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0, 4'b0000, 32'h0, 32'h0);
    add(4'd1, 32'h0000_0002, 32'h0, 32'h80FF_7F01, 1'b0, 5'd4, 4'b0000, 32'h0, 32'h0);
    add(4'd6, 32'h0000_7F08, 32'h1111_1111, 32'h0, 1'b0, 5'd5, 4'b0000, 32'h0, 32'h0);
    add(4'd8, 32'h0000_7F00, 32'h1111_1111, 32'h0, 1'b0, 5'd5, 4'b0000, 32'h0, 32'h0);
    add(4'd1, 32'h0000_3000, 32'h0, 32'h80FF_7F01, 1'b0, 5'd4, 4'b0000, 32'h0, 32'h0);
    add(4'd6, 32'h0000_0020, 32'h2222_2222, 32'h0, 1'b1, 5'd5, 4'b0000, 32'h0, 32'h0);
    add(4'd7, 32'h0000_7F12, 32'h3333_3333, 32'h0, 1'b0, 5'd5, 4'b0000, 32'h0, 32'h0);
    add(4'd1, 32'h0000_7F1C, 32'h0, 32'h80FF_7F01, 1'b0, 5'd4, 4'b0000, 32'h0, 32'h0);
    add(4'd2, 32'h0000_0001, 32'h0, 32'h80FF_7F01, 1'b0, 5'd4, 4'b0000, 32'h0, 32'h0);

    // reset held low for two cycles with a store sitting in M
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_m(0, 4'd6, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 1'b0);
    #1;
    chk("rst_byteen0", {28'h0, m_data_byteen}, 32'h0);
    tick();
    chk("rst_byteen1", {28'h0, m_data_byteen}, 32'h0);
    tick();
    chk("rst_byteen2", {28'h0, m_data_byteen}, 32'h0);
    last_w = '{32'h0000_3000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_q.push_back(last_w);
    check_w("rst");
    reset = 1'b1;

    // table-driven vectors through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      drive_m(i + 1, vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].rdata, vecs[i].ov);
      #1;
      chk($sformatf("v%0d.exc", i), {27'h0, M_exc_code}, {27'h0, vecs[i].exc});
      chk($sformatf("v%0d.byteen", i), {28'h0, m_data_byteen}, {28'h0, vecs[i].be});
      chk($sformatf("v%0d.addr", i), m_data_addr, vecs[i].addr);
      if (vecs[i].be != 4'b0000) begin
        chk($sformatf("v%0d.wdata", i), m_data_wdata, vecs[i].wd);
      end
      push_w(vecs[i].exc != 5'd0, vecs[i].wmem);
      tick();
      check_w($sformatf("v%0d", i));
    end

    // stall for three cycles with sw in M, then release
    drive_m(100, 4'd6, 32'h0000_0010, 32'h55AA_33CC, 32'h0, 1'b0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.byteen", c), {28'h0, m_data_byteen}, 32'h0);
      exp_q.push_back(last_w);
      tick();
      check_w($sformatf("stall%0d", c));
    end
    stall = 1'b0;
    #1;
    chk("release.byteen", {28'h0, m_data_byteen}, 32'h0000_000F);
    chk("release.wdata", m_data_wdata, 32'h55AA_33CC);
    push_w(1'b0, 32'h0);
    tick();
    check_w("release");
    drive_m(101, 4'd0, 32'h0000_0010, 32'h55AA_33CC, 32'h0, 1'b0);
    #1;
    chk("release.once", {28'h0, m_data_byteen}, 32'h0);
    push_w(1'b0, 32'h0);
    tick();
    check_w("after_release");

    // flush and stall together with sw in M: flush wins
    drive_m(102, 4'd6, 32'h0000_0040, 32'h7777_7777, 32'h0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    #1;
    chk("flush_stall.byteen", {28'h0, m_data_byteen}, 32'h0);
    push_w(1'b1, 32'h0);
    tick();
    check_w("flush_stall");

    // flush alone on a legal load: no data reaches W
    drive_m(103, 4'd1, 32'h0000_0008, 32'h0, 32'hCAFE_BABE, 1'b0);
    stall = 1'b0; flush = 1'b1;
    #1;
    chk("flush_load.exc", {27'h0, M_exc_code}, 32'h0);
    push_w(1'b1, 32'h0);
    tick();
    check_w("flush_load");
    flush = 1'b0;

    // stall with a faulting load holds W instead of bubbling
    drive_m(104, 4'd1, 32'h0000_0003, 32'h0, 32'h0, 1'b0);
    stall = 1'b1;
    #1;
    chk("stall_exc.exc", {27'h0, M_exc_code}, 32'h0000_0004);
    exp_q.push_back(last_w);
    tick();
    check_w("stall_exc");
    stall = 1'b0;

    // reset mid-store
    drive_m(105, 4'd6, 32'h0000_0044, 32'h9999_9999, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_mid.byteen", {28'h0, m_data_byteen}, 32'h0);
    exp_q.push_back('{32'h0000_3000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
    tick();
    check_w("rst_mid");
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
